ov7670_sccb_arbiter: RTL and testbench
======================================

Name: ov7670_sccb_arbiter

Overview:
- Shares the single SCCB register-write engine (i2c_sender command interface: send / reg_addr / value / taken) between NREQ requesters.
- Typical requesters: the boot register table, a runtime exposure/gain tuner, and a debug write port.
- Also owns the camera power-up sequence (pwdn, reset) and blocks all grants until the camera has settled.
- Sits between the requester logic and the SCCB sender, in the camera clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- RESET_CYCLES, 1000, cycles cam_reset is held low after power-up sequence start.
- SETTLE_CYCLES, 100000, cycles to wait after reset release before first grant.
- GAP_CYCLES, 8, idle cycles with sccb_send low between consecutive transactions.
- TIMEOUT_CYCLES, 65535, cycles to wait for sccb_taken before aborting.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset, sampled on the clk rising edge.
- restart  in  1  one-cycle pulse; reruns the power-up sequence.
- req  in  NREQ  per-requester request level.
- req_addr  in  8*NREQ  register address; requester i uses bits [8i+7:8i].
- req_data  in  8*NREQ  register value, same packing as req_addr.
- ack  out  NREQ  one-cycle pulse: the write was accepted by the sender.
- err  out  NREQ  one-cycle pulse: the write timed out.
- grant  out  NREQ  one-hot, high while the requester's transaction is owned.
- sccb_send  out  1  command valid to the SCCB sender.
- sccb_reg_addr  out  8  latched address.
- sccb_value  out  8  latched value.
- sccb_taken  in  1  sender acceptance pulse.
- cam_reset  out  1  camera reset, active low.
- cam_pwdn  out  1  camera power-down, active high.
- ready  out  1  power-up sequence complete.

Behaviour:
- All outputs are registered.
- Reset values: cam_pwdn=1, cam_reset=0, ready=0, sccb_send=0, sccb_reg_addr=0, sccb_value=0, grant=0, ack=0, err=0, round-robin pointer=0. State is PWR.
- PWR: hold for 1 cycle (cam_pwdn=1, cam_reset=0), then go to RST.
- RST: cam_pwdn=0, cam_reset=0 for RESET_CYCLES cycles, then go to SETTLE.
- SETTLE: cam_reset=1, count SETTLE_CYCLES cycles, then set ready=1 and go to IDLE.
- IDLE, arbitration:
  - If any req bit is high, pick the first set bit scanning from pointer upward with wrap.
  - In the next cycle: state=ISSUE, grant=onehot(i), sccb_send=1, address and value latched from slot i.
  - pointer <= (i+1) mod NREQ.
  - With no requests, IDLE holds and the pointer is unchanged.
- ISSUE:
  - sccb_send and the latched data stay stable.
  - The timeout counter starts at 0 and increments each cycle.
  - On sccb_taken=1: the next cycle has ack[i]=1 for exactly one cycle, sccb_send=0, grant=0, state=GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without taken: the next cycle has err[i]=1 for one cycle, sccb_send=0, grant=0, state=GAP.
  - If taken arrives in the same cycle as the timeout expiry, taken wins (ack, not err).
- GAP: GAP_CYCLES cycles with sccb_send=0, then go to IDLE. A request is never granted back-to-back with less than GAP_CYCLES of send-low.
- Latency from taken to ack: 1 cycle. Latency from req (while IDLE) to sccb_send: 1 cycle.
- Requesters must hold req and their data until ack or err. Dropping req during ISSUE does not abort the transaction; ack/err is still pulsed. A requester that still has req high after its ack is eligible again, but the round-robin ordering applies.
- sccb_taken outside ISSUE is ignored.
- restart, in any state: next cycle enters PWR with the same output values as reset. The in-flight transaction is abandoned, with no ack and no err. pointer is preserved.
- resetn low overrides restart.
- Counters are sized ceil(log2(max parameter + 1)) bits and never wrap.

Test Plan:
- Power-up, bench params RESET_CYCLES=16, SETTLE_CYCLES=32, GAP_CYCLES=4, TIMEOUT_CYCLES=100, NREQ=4:
  - Release resetn -> cam_pwdn falls at cycle 1, cam_reset rises at cycle 17, ready rises at cycle 49.
  - A req[0] raised at cycle 5 is not granted before ready=1.
- Single write:
  - req[2]=1 with addr=0x12, data=0x80; sender model pulses taken 3 cycles after send -> sccb_reg_addr=0x12 and sccb_value=0x80 while send=1.
  - ack[2] pulses once, one cycle after taken; grant returns to 0.
- Round robin: req=4'b1111 held, taken after 2 cycles each -> grant order 0,1,2,3,0, with at least 4 send-low cycles between grants.
- Timeout: req[1] held and taken never pulsed -> err[1] pulses 100 cycles after send rises, ack stays 0, and the next request is serviced after the gap.
- Taken/timeout collision: taken pulsed exactly in the expiry cycle -> ack[1]=1, err=0.
- restart during ISSUE: pulse restart while send=1 -> send=0, cam_pwdn=1, cam_reset=0 next cycle, no ack/err pulse, and the full sequence repeats.

Source files
------------

// File: rtl/ov7670_sccb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_arbiter_if
//
// Bundles the requester-side and SCCB-sender-side signals of the SCCB write
// arbiter so they travel as one port.
//
//   req            requester -> arbiter  per-requester request level
//   req_addr       requester -> arbiter  register address, slot i = [8i+7:8i]
//   req_data       requester -> arbiter  register value, same packing
//   ack            arbiter -> requester  one-cycle pulse, write accepted
//   err            arbiter -> requester  one-cycle pulse, write timed out
//   grant          arbiter -> requester  one-hot owner of the transaction
//   sccb_send      arbiter -> sender     command valid
//   sccb_reg_addr  arbiter -> sender     latched register address
//   sccb_value     arbiter -> sender     latched register value
//   sccb_taken     sender -> arbiter     acceptance pulse
//
// Modports:
//   slave   the arbiter's view (serves requests, drives the sender)
//   master  the surrounding logic's view (requesters plus sender)
// ---------------------------------------------------------------------------
interface ov7670_sccb_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   err;
    logic [NREQ-1:0]   grant;
    logic              sccb_send;
    logic [7:0]        sccb_reg_addr;
    logic [7:0]        sccb_value;
    logic              sccb_taken;

    modport slave (
        input  req, req_addr, req_data, sccb_taken,
        output ack, err, grant, sccb_send, sccb_reg_addr, sccb_value
    );

    modport master (
        output req, req_addr, req_data, sccb_taken,
        input  ack, err, grant, sccb_send, sccb_reg_addr, sccb_value
    );
endinterface

// File: rtl/ov7670_sccb_arbiter.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_arbiter
//
// Shares one SCCB register-write engine between NREQ requesters (boot table,
// exposure/gain tuner, debug port, ...) using round-robin arbitration, and
// owns the camera power-up sequence. No grant is issued until the camera has
// been powered, reset and allowed to settle.
//
// Ports:
//   clk        in   camera-domain clock
//   resetn     in   synchronous active-low reset
//   restart    in   one-cycle pulse, reruns the power-up sequence
//   bus        slave modport of ov7670_sccb_arbiter_if (requesters + sender)
//   cam_reset  out  camera reset, active low
//   cam_pwdn   out  camera power-down, active high
//   ready      out  power-up sequence complete
//
// Sequence: PWR (1 cycle) -> RST (RESET_CYCLES) -> SETTLE (SETTLE_CYCLES)
//           -> IDLE <-> ISSUE -> GAP (GAP_CYCLES) -> IDLE ...
// All outputs come straight from flops. The bus parameter NREQ must match
// the module parameter NREQ.
// ---------------------------------------------------------------------------
module ov7670_sccb_arbiter #(
    parameter int NREQ           = 4,
    parameter int RESET_CYCLES   = 1000,
    parameter int SETTLE_CYCLES  = 100000,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         restart,
    ov7670_sccb_arbiter_if.slave         bus,
    output logic                         cam_reset,
    output logic                         cam_pwdn,
    output logic                         ready
);

    // One shared counter serves every timed state, so it is sized for the
    // largest of the cycle parameters.
    localparam int MAX_AB  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CD  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PWR,
        ST_RST,
        ST_SETTLE,
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } state_e;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [PTR_W-1:0]  ptr_q,       ptr_d;
    logic [NREQ-1:0]   grant_q,     grant_d;
    logic [NREQ-1:0]   ack_q,       ack_d;
    logic [NREQ-1:0]   err_q,       err_d;
    logic              send_q,      send_d;
    logic [7:0]        addr_q,      addr_d;
    logic [7:0]        value_q,     value_d;
    logic              cam_reset_q, cam_reset_d;
    logic              cam_pwdn_q,  cam_pwdn_d;
    logic              ready_q,     ready_d;

    // -----------------------------------------------------------------------
    // Slot unpacking: requester i owns byte i of req_addr / req_data.
    // -----------------------------------------------------------------------
    logic [7:0] slot_addr [NREQ];
    logic [7:0] slot_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot_addr[g] = bus.req_addr[8*g +: 8];
        assign slot_data[g] = bus.req_data[8*g +: 8];
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first requesting slot at or after the pointer, with
    // wrap. The pointer only moves when a grant is actually issued.
    // -----------------------------------------------------------------------
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic [NREQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]  cand;
    logic [PTR_W-1:0]  ptr_after_pick;

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NREQ);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid        = 1'b1;
                pick_idx          = cand;
                pick_onehot       = '0;
                pick_onehot[cand] = 1'b1;
            end
        end
        ptr_after_pick = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        send_d      = send_q;
        addr_d      = addr_q;
        value_d     = value_q;
        cam_reset_d = cam_reset_q;
        cam_pwdn_d  = cam_pwdn_q;
        ready_d     = ready_q;
        ack_d       = '0;   // pulses: high for one cycle only
        err_d       = '0;

        unique case (state_q)
            ST_PWR: begin
                // Power rail has been up for one cycle: leave power-down and
                // start the reset-low window.
                state_d     = ST_RST;
                cnt_d       = '0;
                cam_pwdn_d  = 1'b0;
                cam_reset_d = 1'b0;
            end

            ST_RST: begin
                if (cnt_q == RESET_LAST) begin
                    state_d     = ST_SETTLE;
                    cnt_d       = '0;
                    cam_reset_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                    grant_d = pick_onehot;
                    send_d  = 1'b1;
                    addr_d  = slot_addr[pick_idx];
                    value_d = slot_data[pick_idx];
                    ptr_d   = ptr_after_pick;
                end
            end

            ST_ISSUE: begin
                // grant_q is the owner's one-hot, so it doubles as the
                // ack/err pulse pattern. taken is tested first so that a
                // taken in the expiry cycle still counts as success.
                if (bus.sccb_taken) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    ack_d   = grant_q;
                    grant_d = '0;
                    send_d  = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    err_d   = grant_q;
                    grant_d = '0;
                    send_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_PWR;
                cnt_d   = '0;
            end
        endcase

        // restart abandons whatever is in flight (no ack, no err) and
        // reloads the reset values; only the round-robin pointer survives.
        if (restart) begin
            state_d     = ST_PWR;
            cnt_d       = '0;
            ptr_d       = ptr_q;
            grant_d     = '0;
            send_d      = 1'b0;
            addr_d      = '0;
            value_d     = '0;
            ack_d       = '0;
            err_d       = '0;
            cam_reset_d = 1'b0;
            cam_pwdn_d  = 1'b1;
            ready_d     = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State register. resetn is sampled on the clock edge and wins over
    // restart.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, whatever the statement order.
        if (!resetn) begin
            state_q     <= ST_PWR;
            cnt_q       <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            send_q      <= 1'b0;
            addr_q      <= '0;
            value_q     <= '0;
            cam_reset_q <= 1'b0;
            cam_pwdn_q  <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            send_q      <= send_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            cam_reset_q <= cam_reset_d;
            cam_pwdn_q  <= cam_pwdn_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.ack           = ack_q;
    assign bus.err           = err_q;
    assign bus.sccb_send     = send_q;
    assign bus.sccb_reg_addr = addr_q;
    assign bus.sccb_value    = value_q;
    assign cam_reset         = cam_reset_q;
    assign cam_pwdn          = cam_pwdn_q;
    assign ready             = ready_q;

endmodule

// File: tb/tb_ov7670_sccb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_arbiter
//
// Directed power-up / single-write / round-robin / timeout / collision /
// restart steps followed by randomized transactions. Expected behaviour comes
// from a transaction-level model: a round-robin priority list rebuilt from
// the model pointer for each grant, and fixed latencies derived from the
// cycle parameters. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ov7670_sccb_arbiter;

    localparam int NREQ           = 4;
    localparam int RESET_CYCLES   = 16;
    localparam int SETTLE_CYCLES  = 32;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 100;

    // Edge numbers, counted from the first edge after reset release/restart.
    localparam int PWDN_FALL  = 1;
    localparam int RESET_RISE = PWDN_FALL + RESET_CYCLES;
    localparam int READY_RISE = RESET_RISE + SETTLE_CYCLES;

    logic clk = 1'b0;
    logic resetn;
    logic restart;
    logic cam_reset;
    logic cam_pwdn;
    logic ready;

    int errors    = 0;
    int checks    = 0;
    int model_ptr = 0;
    int rr_expect [5] = '{0, 1, 2, 3, 0};

    ov7670_sccb_arbiter_if #(.NREQ(NREQ)) bus ();

    ov7670_sccb_arbiter #(
        .NREQ           (NREQ),
        .RESET_CYCLES   (RESET_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .restart   (restart),
        .bus       (bus),
        .cam_reset (cam_reset),
        .cam_pwdn  (cam_pwdn),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        if (idx >= 0 && idx < NREQ) v[idx] = 1'b1;
        return v;
    endfunction

    // Priority list = pointer, pointer+1, ... with wrap; first requester wins.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
        int order [$];
        int res;
        res = -1;
        for (int k = 0; k < NREQ; k++) order.push_back((ptr + k) % NREQ);
        foreach (order[j]) begin
            if (res < 0 && r[order[j]]) res = order[j];
        end
        return res;
    endfunction

    // Power-up from the edge after reset release / restart: pwdn low from
    // edge 1, reset high from edge 17, ready from edge 49; nothing granted.
    task automatic check_powerup(input bit raise_req0);
        for (int n = 1; n <= READY_RISE; n++) begin
            tick();
            if (raise_req0 && n == 5) bus.req[0] = 1'b1;
            check($sformatf("powerup@%0d", n),
                  {cam_pwdn, cam_reset, ready, bus.sccb_send, |bus.grant, |bus.ack, |bus.err},
                  {n < PWDN_FALL, n >= RESET_RISE, n >= READY_RISE, 4'b0000});
        end
    endtask

    // One transaction starting from IDLE. The sender raises taken so that it
    // is sampled 'delay' edges after the grant edge; delay > TIMEOUT_CYCLES
    // means the sender never answers.
    task automatic run_txn(input logic [NREQ-1:0] reqv, input int delay,
                           input bit drop, output int got_idx);
        int              idx;
        int              end_k;
        bit              exp_ack;
        logic [7:0]      ea;
        logic [7:0]      ed;
        logic [NREQ-1:0] oh;

        idx = rr_pick(reqv, model_ptr);
        oh  = onehot(idx);
        ea  = bus.req_addr[8*idx +: 8];
        ed  = bus.req_data[8*idx +: 8];

        bus.req        = reqv;
        bus.sccb_taken = 1'b0;
        tick();
        check("grant", {bus.sccb_send, bus.sccb_reg_addr, bus.sccb_value, bus.grant},
              {1'b1, ea, ed, oh});
        got_idx = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (bus.grant === onehot(k)) got_idx = k;
        end
        model_ptr = (idx + 1) % NREQ;
        if (drop) bus.req = '0;

        exp_ack = (delay <= TIMEOUT_CYCLES);
        end_k   = exp_ack ? delay : TIMEOUT_CYCLES;
        for (int k = 1; k <= end_k; k++) begin
            bus.sccb_taken = (k == delay);
            tick();
            bus.sccb_taken = 1'b0;
            if (k < end_k)
                check("issue_hold",
                      {bus.sccb_send, bus.sccb_reg_addr, bus.sccb_value, bus.grant, bus.ack, bus.err},
                      {1'b1, ea, ed, oh, {2*NREQ{1'b0}}});
        end
        check(exp_ack ? "ack_pulse" : "err_pulse",
              {bus.sccb_send, bus.grant, bus.ack, bus.err},
              {1'b0, {NREQ{1'b0}}, exp_ack ? oh : {NREQ{1'b0}}, exp_ack ? {NREQ{1'b0}} : oh});

        // Gap: send stays low; stray taken pulses must be ignored.
        for (int g = 0; g < GAP_CYCLES; g++) begin
            bus.sccb_taken = 1'($urandom_range(0, 1));
            tick();
            check("gap_idle", {bus.sccb_send, bus.grant, bus.ack, bus.err}, '0);
        end
        bus.sccb_taken = 1'b0;
    endtask

    initial begin
        int got;
        int r;
        int delay;

        resetn         = 1'b0;
        restart        = 1'b0;
        bus.req        = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.sccb_taken = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_ctrl",
              {cam_pwdn, cam_reset, ready, bus.sccb_send, bus.grant, bus.ack, bus.err},
              {1'b1, 1'b0, 1'b0, 1'b0, {3*NREQ{1'b0}}});
        check("reset_latch", {bus.sccb_reg_addr, bus.sccb_value}, 16'h0000);

        // Power-up with req[0] raised early
        bus.req_addr[7:0] = 8'h0A;
        bus.req_data[7:0] = 8'h55;
        resetn = 1'b1;
        check_powerup(1'b1);
        run_txn(4'b0001, 3, 1'b0, got);
        check("first_owner", 32'(got), 32'd0);

        // Single write from requester 2
        bus.req_addr[23:16] = 8'h12;
        bus.req_data[23:16] = 8'h80;
        run_txn(4'b0100, 3, 1'b0, got);
        check("single_owner", 32'(got), 32'd2);

        // Move the pointer back to 0, then round robin over all four
        bus.req_addr[31:24] = 8'h3A;
        bus.req_data[31:24] = 8'hA3;
        bus.req_addr[15:8]  = 8'h11;
        bus.req_data[15:8]  = 8'h22;
        run_txn(4'b1000, 1, 1'b0, got);
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 2, 1'b0, got);
            check($sformatf("rr_order%0d", i), 32'(got), 32'(rr_expect[i]));
        end

        // Timeout on requester 1, then the next request after the gap
        bus.req_addr[15:8] = 8'h6B;
        bus.req_data[15:8] = 8'h01;
        run_txn(4'b0010, TIMEOUT_CYCLES + 1, 1'b0, got);
        check("timeout_owner", 32'(got), 32'd1);
        run_txn(4'b0100, 2, 1'b0, got);
        check("after_timeout", 32'(got), 32'd2);

        // taken in the expiry cycle: ack wins
        run_txn(4'b0010, TIMEOUT_CYCLES, 1'b0, got);
        check("collision_owner", 32'(got), 32'd1);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            for (int s = 0; s < NREQ; s++) begin
                bus.req_addr[8*s +: 8] = 8'($urandom);
                bus.req_data[8*s +: 8] = 8'($urandom);
            end
            r = int'($urandom_range(0, 9));
            if (r < 7)       delay = int'($urandom_range(1, 5));
            else if (r == 7) delay = TIMEOUT_CYCLES - 1;
            else if (r == 8) delay = TIMEOUT_CYCLES;
            else             delay = TIMEOUT_CYCLES + 1;
            run_txn(NREQ'($urandom_range(1, 15)), delay, ($urandom_range(0, 3) == 0), got);
        end

        // restart during ISSUE (with a coincident taken): no ack, full rerun
        bus.req_addr[7:0] = 8'h3C;
        bus.req_data[7:0] = 8'hC3;
        got = rr_pick(4'b0001, model_ptr);
        bus.req = 4'b0001;
        tick();
        check("restart_issue", {bus.sccb_send, bus.grant}, {1'b1, onehot(got)});
        model_ptr = (got + 1) % NREQ;
        tick();
        restart        = 1'b1;
        bus.sccb_taken = 1'b1;
        tick();
        restart        = 1'b0;
        bus.sccb_taken = 1'b0;
        check("restart_ctrl",
              {cam_pwdn, cam_reset, ready, bus.sccb_send, bus.grant, bus.ack, bus.err},
              {1'b1, 1'b0, 1'b0, 1'b0, {3*NREQ{1'b0}}});
        check("restart_latch", {bus.sccb_reg_addr, bus.sccb_value}, 16'h0000);
        check_powerup(1'b0);
        run_txn(4'b1111, 2, 1'b0, got);
        check("ptr_kept", 32'(got), 32'(rr_pick(4'b1111, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
